// File: rtl/sort_floats_pkg.sv
// Shared definitions for the sequential float sorter.
// Contents:
//   state_t   - controller states (IDLE, SORT, DONE)
//   MAX_CMP   - worst-case compare count for the default N=4 build
//   expWidth  - exponent field width for a given IEEE-754 format width
//   maxCmp    - worst-case bubble-sort compare count for any N
package sort_floats_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT    = 4;
  localparam int FLEN_DEFAULT = 64;
  localparam int MAX_CMP      = N_DEFAULT * (N_DEFAULT - 1) / 2;

  // Half, single, double and quad precision; anything else is treated as double.
  function automatic int expWidth(input int flen);
    case (flen)
      16:      return 5;
      32:      return 8;
      128:     return 15;
      default: return 11;
    endcase
  endfunction

  function automatic int maxCmp(input int n);
    return n * (n - 1) / 2;
  endfunction

endpackage

// File: rtl/sort_floats_seq_if.sv
// Handshake bundle between a vector producer/consumer and the sorter.
// Signals:
//   up_valid / up_ready     - unsorted vector handshake (producer -> sorter)
//   unsorted [0:N-1]        - input vector, element 0 first
//   down_valid / down_ready - sorted result handshake (sorter -> consumer)
//   sorted [0:N-1]          - ascending result
//   err                     - a NaN operand was seen while sorting this vector
// Modports: master = producer/consumer side, slave = sorter side.
interface sort_floats_seq_if #(
  parameter int N    = 4,
  parameter int FLEN = 64
);
  logic                     up_valid;
  logic                     up_ready;
  logic [0:N-1][FLEN-1:0]   unsorted;
  logic                     down_valid;
  logic                     down_ready;
  logic [0:N-1][FLEN-1:0]   sorted;
  logic                     err;

  modport master (
    output up_valid, unsorted, down_ready,
    input  up_ready, down_valid, sorted, err
  );

  modport slave (
    input  up_valid, unsorted, down_ready,
    output up_ready, down_valid, sorted, err
  );
endinterface

// File: rtl/f_less_or_equal.sv
// Combinational IEEE-754 "a <= b" comparator.
// Ports:
//   i_a, i_b - FLEN-bit floating-point operands
//   o_res    - 1 when a <= b; 0 when a > b or either operand is NaN
//   o_err    - 1 when either operand is NaN (the comparison is unordered)
// +0 and -0 compare equal.
module f_less_or_equal
  import sort_floats_pkg::*;
#(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] i_a,
  input  logic [FLEN-1:0] i_b,
  output logic            o_res,
  output logic            o_err
);

  localparam int EW = expWidth(FLEN);
  localparam int MW = FLEN - 1 - EW;

  logic            w_signA, w_signB;
  logic [FLEN-2:0] w_magA, w_magB;
  logic            w_nanA, w_nanB;
  logic            w_bothZero;

  assign w_signA = i_a[FLEN-1];
  assign w_signB = i_b[FLEN-1];
  assign w_magA  = i_a[FLEN-2:0];
  assign w_magB  = i_b[FLEN-2:0];

  // NaN: exponent all ones with a non-zero mantissa (infinity is ordered).
  assign w_nanA = (&i_a[FLEN-2 -: EW]) && (|i_a[MW-1:0]);
  assign w_nanB = (&i_b[FLEN-2 -: EW]) && (|i_b[MW-1:0]);

  assign w_bothZero = (w_magA == '0) && (w_magB == '0);

  // Sign-magnitude ordering: differing signs are decided by the sign alone,
  // negative numbers order by reversed magnitude.
  always_comb begin
    o_err = w_nanA || w_nanB;
    o_res = 1'b0;
    if (o_err)
      o_res = 1'b0;
    else if (w_bothZero)
      o_res = 1'b1;
    else if (w_signA != w_signB)
      o_res = w_signA;
    else if (!w_signA)
      o_res = (w_magA <= w_magB);
    else
      o_res = (w_magA >= w_magB);
  end

endmodule

// File: rtl/sort_floats_seq.sv
// Sequential N-element float sorter sharing a single comparator.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - slave side of sort_floats_seq_if (input vector handshake,
//          sorted output handshake, err flag)
// A vector is bubble-sorted in place, one adjacent compare per clock, and a
// pass with no swap ends the sort early. Equal elements are never swapped,
// so the sort is stable.
module sort_floats_seq
  import sort_floats_pkg::*;
#(
  parameter int N     = 4,
  parameter int FLEN  = 64,
  parameter int CNT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  sort_floats_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 2);

  state_t                  r_state, w_stateNext;
  logic [0:N-1][FLEN-1:0]  r_data, w_dataNext;
  logic [CNT_W-1:0]        r_pass, w_passNext;
  logic [CNT_W-1:0]        r_idx, w_idxNext;
  logic                    r_swapFlag, w_swapFlagNext;
  logic                    r_err, w_errNext;

  logic [FLEN-1:0]         w_a, w_b;
  logic                    w_res, w_cmpErr;
  logic                    w_swap;
  logic [CNT_W-1:0]        w_idxPlus;
  logic [CNT_W-1:0]        w_lastIdx;

  assign w_idxPlus = r_idx + CNT_W'(1);
  assign w_lastIdx = LAST - r_pass;
  assign w_a       = r_data[r_idx];
  assign w_b       = r_data[w_idxPlus];

  f_less_or_equal #(.FLEN(FLEN)) i_floe (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_res (w_res),
    .o_err (w_cmpErr)
  );

  assign bus.up_ready   = (r_state == IDLE);
  assign bus.down_valid = (r_state == DONE);
  assign bus.sorted     = r_data;
  assign bus.err        = r_err;

  // Next-state and datapath decisions. Each pass ends one slot earlier than
  // the previous one because the largest remaining element has bubbled to
  // the top; a clean pass or the final pass moves to DONE.
  always_comb begin
    w_stateNext    = r_state;
    w_dataNext     = r_data;
    w_passNext     = r_pass;
    w_idxNext      = r_idx;
    w_swapFlagNext = r_swapFlag;
    w_errNext      = r_err;
    w_swap         = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.up_valid) begin
          w_dataNext     = bus.unsorted;
          w_passNext     = '0;
          w_idxNext      = '0;
          w_swapFlagNext = 1'b0;
          w_errNext      = 1'b0;
          w_stateNext    = SORT;
        end
      end
      SORT: begin
        w_swap    = !w_res;
        w_errNext = r_err | w_cmpErr;
        if (w_swap) begin
          w_dataNext[r_idx]     = w_b;
          w_dataNext[w_idxPlus] = w_a;
          w_swapFlagNext        = 1'b1;
        end
        if (r_idx == w_lastIdx) begin
          if ((r_pass == LAST) || !(r_swapFlag || w_swap)) begin
            w_stateNext = DONE;
          end else begin
            w_passNext     = r_pass + CNT_W'(1);
            w_idxNext      = '0;
            w_swapFlagNext = 1'b0;
          end
        end else begin
          w_idxNext = w_idxPlus;
        end
      end
      DONE: begin
        if (bus.down_ready)
          w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_pass     <= '0;
      r_idx      <= '0;
      r_swapFlag <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_data     <= w_dataNext;
      r_pass     <= w_passNext;
      r_idx      <= w_idxNext;
      r_swapFlag <= w_swapFlagNext;
      r_err      <= w_errNext;
    end
  end

endmodule

// File: tb/tb_sort_floats_seq.sv
// Scoreboard bench for sort_floats_seq (N=4, FLEN=64).
module tb_sort_floats_seq;
  import sort_floats_pkg::*;

  localparam int N    = 4;
  localparam int FLEN = 64;

  localparam logic [63:0] P1  = 64'h3FF0000000000000;
  localparam logic [63:0] P2  = 64'h4000000000000000;
  localparam logic [63:0] P3  = 64'h4008000000000000;
  localparam logic [63:0] M1  = 64'hBFF0000000000000;
  localparam logic [63:0] QN  = 64'h7FF8000000000000;
  localparam logic [63:0] PZ  = 64'h0000000000000000;
  localparam logic [63:0] MZ  = 64'h8000000000000000;

  typedef logic [0:N-1][FLEN-1:0] vec_t;

  typedef struct {
    vec_t expSorted;
    logic expErr;
    int   expC;
    bit   checkSorted;
    bit   checkC;
    int   acceptCyc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   prevDv = 1'b0;
  item_t q[$];

  sort_floats_seq_if #(.N(N), .FLEN(FLEN)) bus ();

  sort_floats_seq #(.N(N), .FLEN(FLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic item_t mkItem(input vec_t s, input logic e, input int c, input bit cs, input bit cc);
    item_t it;
    it.expSorted   = s;
    it.expErr      = e;
    it.expC        = c;
    it.checkSorted = cs;
    it.checkC      = cc;
    it.acceptCyc   = 0;
    return it;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic applyStimulus(input vec_t v, input item_t it, input bit track);
    int waitN = 0;
    bus.unsorted = v;
    bus.up_valid = 1'b1;
    while (!bus.up_ready && waitN < 200) begin
      @(negedge clk);
      waitN++;
    end
    if (!bus.up_ready) begin
      checkOutput("acceptTimeout", 256'(0), 256'(1));
      bus.up_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.up_valid = 1'b0;
    it.acceptCyc = cyc;
    if (track) q.push_back(it);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checkOutput("doneTimeout", 256'(q.size()), 256'(0));
      q.delete();
    end
  endtask

  // Monitor: compares the DUT result against the scoreboard head every
  // cycle down_valid is high, and pops on the handshake.
  always begin
    @(negedge clk);
    #1;
    if (bus.down_valid) begin
      if (q.size() == 0) begin
        checkOutput("unexpectedDownValid", 256'(1), 256'(0));
      end else begin
        if (!prevDv && q[0].checkC)
          checkOutput("latency", 256'(cyc - q[0].acceptCyc), 256'(q[0].expC));
        if (q[0].checkSorted)
          checkOutput("sorted", bus.sorted, q[0].expSorted);
        checkOutput("err", 256'(bus.err), 256'(q[0].expErr));
        if (bus.down_ready) begin
          void'(q.pop_front());
          prevDv = 1'b0;
        end else begin
          prevDv = 1'b1;
        end
      end
    end else begin
      prevDv = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t rev;
    rev = {P3, P2, P1, M1};
    bus.up_valid   = 1'b0;
    bus.unsorted   = '0;
    bus.down_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("resetUpReady",   256'(bus.up_ready),   256'(1));
    checkOutput("resetDownValid", 256'(bus.down_valid), 256'(0));
    checkOutput("resetSorted",    bus.sorted,           256'(0));
    checkOutput("resetErr",       256'(bus.err),        256'(0));

    // Already sorted: one clean pass.
    applyStimulus({M1, P1, P2, P3}, mkItem({M1, P1, P2, P3}, 1'b0, 3, 1, 1), 1);
    waitIdle();

    // Reversed: worst case.
    applyStimulus(rev, mkItem({M1, P1, P2, P3}, 1'b0, 6, 1, 1), 1);
    waitIdle();

    // Duplicates: two passes.
    applyStimulus({P2, P1, P1, P3}, mkItem({P1, P1, P2, P3}, 1'b0, 5, 1, 1), 1);
    waitIdle();

    // Stability: -0 and +0 compare equal but are distinguishable.
    applyStimulus({P2, MZ, PZ, P3}, mkItem({MZ, PZ, P2, P3}, 1'b0, 5, 1, 1), 1);
    waitIdle();

    // NaN: order unspecified, err must be set.
    applyStimulus({P1, QN, P2, P3}, mkItem('0, 1'b1, 0, 0, 0), 1);
    waitIdle();

    // Backpressure: result held while down_ready is low.
    bus.down_ready = 1'b0;
    applyStimulus({P3, P1, P2, M1}, mkItem({M1, P1, P2, P3}, 1'b0, 6, 1, 1), 1);
    begin
      int n = 0;
      while (!bus.down_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("bpReachedDone", 256'(bus.down_valid), 256'(1));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.unsorted = {P3, P3, P3, P3};
      bus.up_valid = (i % 2 == 0);
      checkOutput("bpUpReady",   256'(bus.up_ready),   256'(0));
      checkOutput("bpDownValid", 256'(bus.down_valid), 256'(1));
    end
    @(negedge clk);
    bus.up_valid   = 1'b0;
    bus.down_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpIdleUpReady",   256'(bus.up_ready),   256'(1));
    checkOutput("bpIdleDownValid", 256'(bus.down_valid), 256'(0));
    applyStimulus({P2, P1, P3, M1}, mkItem({M1, P1, P2, P3}, 1'b0, 6, 1, 1), 1);
    waitIdle();

    // Reset during the third SORT cycle abandons the vector.
    applyStimulus(rev, mkItem('0, 1'b0, 0, 0, 0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midResetUpReady",   256'(bus.up_ready),   256'(1));
    checkOutput("midResetDownValid", 256'(bus.down_valid), 256'(0));
    checkOutput("midResetSorted",    bus.sorted,           256'(0));
    checkOutput("midResetErr",       256'(bus.err),        256'(0));
    applyStimulus(rev, mkItem({M1, P1, P2, P3}, 1'b0, 6, 1, 1), 1);
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("pendingItems", 256'(q.size()), 256'(0));
    checkOutput("maxCmp", 256'(maxCmp(N)), 256'(6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
